mem_resp_ctrl: RTL and testbench
================================

// Module: mem_resp_ctrl
// PURPOSE
//  Sequences data-bus responses for the MEM/WB pipe. Tracks outstanding data requests in issue order,
//  matches each data_data_ok to its request, and routes load data into WriteBack only when WB holds that
//  load. Drops store acks and flushed loads, and throttles new requests at the outstanding limit.
//  Sits between the MEM-stage request issuer, the data SRAM-like bus response side, and WriteBack (its "ready").
// PARAMETERS
//  MAX_OUTST  2   max in-flight data requests (1..4); request-kind FIFO depth
//  DATA_W     32  data bus width
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  req_fire_i     in   1       MEM request accepted this cycle (data_req && data_addr_ok)
//  req_wr_i       in   1       accepted request is a store (valid with req_fire_i)
//  req_allow_o    out  1       MEM may issue: outstanding < MAX_OUTST
//  data_data_ok_i in   1       bus response beat, in request order
//  data_rdata_i   in   DATA_W  bus response data
//  wb_need_i      in   1       WB holds a valid load awaiting data
//  wb_consume_i   in   1       WB retires that load this cycle
//  wb_ready_o     out  1       load data available to WB this cycle
//  wb_rdata_o     out  DATA_W  load data to WB (bypass or held)
//  flush_i        in   1       exception/eret flush; all in-flight requests become stale
//  outst_cnt_o    out  3       requests in flight (incl. stale)
//  busy_o         out  1       state != IDLE
// BEHAVIOUR
//  Reset: FIFO empty, outst=0, cancel=0, hold_v=0, hold_data=0, state=IDLE; req_allow_o=1, wb_ready_o=0, wb_rdata_o=0.
//  Kind FIFO: push {req_wr_i} on req_fire_i; pop on data_data_ok_i. Same-cycle push+pop: count unchanged.
//  outst = FIFO count; req_allow_o = outst<MAX_OUTST (combinational). req_fire_i when full: assertion error.
//  data_data_ok_i with empty FIFO: assertion error; ignored.
//  Response classes at pop: cancel>0 -> drop, cancel-=1; head=store -> drop; head=load -> live.
//  Live load: if !hold_v and wb_need_i -> bypass: wb_ready_o=1 same cycle, wb_rdata_o=data_rdata_i (0 latency).
//   If not consumed that cycle, capture into hold register (hold_v=1). hold_v=1 -> wb_ready_o=1, wb_rdata_o=hold_data.
//   Live load while !wb_need_i: captured to hold (WB arrives later). hold_v cleared on wb_consume_i.
//  wb_ready_o=0 whenever wb_need_i=0; wb_rdata_o=0 when wb_ready_o=0.
//  flush_i: cancel <= outst - (data_data_ok_i?1:0) + (req_fire_i?1:0) (same-cycle fire also stale);
//   hold_v <= 0; same-cycle live load dropped. Flush during DRAIN accumulates the same way.
//  FSM: IDLE (outst=0,!hold_v) -> WAIT on req_fire_i; WAIT -> HOLD when load captured;
//   HOLD -> WAIT/IDLE on wb_consume_i per outst; any -> DRAIN on flush_i with resulting cancel>0;
//   DRAIN -> IDLE when cancel reaches 0 and outst=0, -> WAIT if new requests pending. Flush with nothing in flight -> IDLE.
//  Reset mid-operation: all state to reset values next edge; in-flight responses are the bus's responsibility.
//  Widths: counters 3 bits; cancel never exceeds outst (assertion).
// CONFIGURATION
//  MEM_RESP_STAT_EN defined: adds outputs stat_stall_o[31:0] (cycles wb_need_i && !wb_ready_o) and
//   stat_drop_o[31:0] (cancelled responses); both saturate at 32'hFFFF_FFFF, reset to 0.
//  Undefined: ports and counters absent; no other behaviour changes.
// STRUCTURE
//  MyDefines.v: `SINGLE_WORD, FSM encodings `MRC_IDLE=2'd0 `MRC_WAIT=2'd1 `MRC_HOLD=2'd2 `MRC_DRAIN=2'd3.
//  Sub-module: mem_resp_fifo (1-bit wide, MAX_OUTST deep, count out, push/pop same cycle).
// TESTING
//  1 Load issue, data_ok 3 cycles later with wb_need_i=1, rdata=32'hDEADBEEF -> wb_ready_o=1 that cycle, wb_rdata_o=DEADBEEF.
//  2 Load data_ok before wb_need_i, rdata=32'h1234 -> held; wb_need_i 2 cycles later -> wb_ready_o=1, data 1234; cleared on consume.
//  3 Store then load; first data_ok -> no wb_ready_o; second (32'hA5A5A5A5) -> delivered; outst 2->1->0.
//  4 Two loads in flight, flush_i -> cancel=2; next two data_ok dropped, wb_ready_o stays 0; state DRAIN->IDLE.
//  5 outst=MAX_OUTST -> req_allow_o=0; data_ok and req_fire_i same cycle -> outst unchanged, req_allow_o=0.
//  6 Flush same cycle as req_fire_i and live data_ok with outst=1 -> data dropped, cancel=1, hold_v=0.

Source files
------------

// File: rtl/mem_resp_ctrl_pkg.sv
// Shared types and helpers for the MEM/WB data-response controller.
//   mrc_state_e : controller FSM encoding (Idle/Wait/Hold/Drain = 0/1/2/3)
//   CNT_W       : width of outstanding/cancel counters
//   sat_inc     : saturating increment for the optional statistics counters
package mem_resp_ctrl_pkg;

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } mrc_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Request-kind FIFO: one bit per in-flight data request (1 = store), kept in issue order.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push_i     enqueue din_i (caller guarantees space, or a same-cycle pop)
//   pop_i      dequeue head (caller guarantees non-empty)
//   din_i      kind of the pushed request
//   head_o     kind of the oldest request
//   count_o    number of entries
module mem_resp_fifo
    import mem_resp_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             din_i,
    output logic             head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;

    // Shift-register organisation: head always sits in entry 0, so no pointers are needed.
    always_comb begin
        mem_d   = pop_i ? (mem_q >> 1) : mem_q;
        wr_idx  = count_q - CNT_W'(pop_i);
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push_i && (wr_idx == CNT_W'(i))) begin
                mem_d[i] = din_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/mem_resp_ctrl.sv
// MEM/WB data-response sequencer. Tracks in-flight data requests in issue order, pairs each
// data_data_ok_i with its request, forwards load data to WriteBack (0-latency bypass or from a
// one-entry hold register), drops store acks and responses made stale by a flush, and throttles
// new requests at MAX_OUTST.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_fire_i, req_wr_i        request accepted this cycle / it is a store
//   req_allow_o                 MEM may issue (outstanding < MAX_OUTST)
//   data_data_ok_i, data_rdata_i  in-order bus response beat and its data
//   wb_need_i, wb_consume_i     WB holds a load awaiting data / WB retires it this cycle
//   wb_ready_o, wb_rdata_o      load data valid for WB / the data (0 when not ready)
//   flush_i                     all in-flight requests become stale
//   outst_cnt_o, busy_o         requests in flight (incl. stale) / FSM not idle
// Optional (MEM_RESP_STAT_EN defined):
//   stat_stall_o                cycles with wb_need_i && !wb_ready_o (saturating)
//   stat_drop_o                 responses discarded as stale (saturating)
module mem_resp_ctrl
    import mem_resp_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_fire_i,
    input  logic              req_wr_i,
    output logic              req_allow_o,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              wb_need_i,
    input  logic              wb_consume_i,
    output logic              wb_ready_o,
    output logic [DATA_W-1:0] wb_rdata_o,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  outst_cnt_o,
    output logic              busy_o
`ifdef MEM_RESP_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_stall_o,
    output logic [STAT_W-1:0] stat_drop_o
`endif
);

    logic [CNT_W-1:0]  count;
    logic              head_wr;
    logic              full, pop, push;
    logic              drop_stale, live, bypass;
    logic [CNT_W-1:0]  cancel_q, cancel_d;
    logic [CNT_W-1:0]  outst_next;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    mrc_state_e        state_q, state_d;

    assign full = (count == CNT_W'(MAX_OUTST));
    assign pop  = data_data_ok_i && (count != '0);
    // A fire at the limit is only accepted when a response frees a slot in the same cycle.
    assign push = req_fire_i && (!full || pop);

    mem_resp_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_kind_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (req_wr_i),
        .head_o  (head_wr),
        .count_o (count)
    );

    always_comb begin
        drop_stale = pop && (cancel_q != '0);
        // A flush in the same cycle kills the response that would otherwise be live.
        live       = pop && (cancel_q == '0) && !head_wr && !flush_i;
        bypass     = live && !hold_v_q && wb_need_i;
        outst_next = count - CNT_W'(pop) + CNT_W'(push);

        req_allow_o = (count < CNT_W'(MAX_OUTST));
        wb_ready_o  = wb_need_i && (hold_v_q || bypass);
        wb_rdata_o  = '0;
        if (wb_ready_o) begin
            wb_rdata_o = hold_v_q ? hold_q : data_rdata_i;
        end

        cancel_d = cancel_q;
        if (drop_stale) begin
            cancel_d = cancel_q - CNT_W'(1);
        end
        if (flush_i) begin
            cancel_d = outst_next;
        end

        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        if (hold_v_q && wb_consume_i) begin
            hold_v_d = 1'b0;
        end
        if (live && !(bypass && wb_consume_i)) begin
            hold_v_d = 1'b1;
            hold_d   = data_rdata_i;
        end
        if (flush_i) begin
            hold_v_d = 1'b0;
        end

        // Next state follows from the next-cycle counters and hold flag.
        state_d = state_q;
        if (cancel_d != '0) begin
            state_d = StDrain;
        end else if (hold_v_d) begin
            state_d = StHold;
        end else if (outst_next != '0) begin
            state_d = StWait;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cancel_q <= '0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            state_q  <= StIdle;
        end else begin
            cancel_q <= cancel_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
        end
    end

    assign outst_cnt_o = count;
    assign busy_o      = (state_q != StIdle);

`ifdef MEM_RESP_STAT_EN
    logic [STAT_W-1:0] stall_q, drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (wb_need_i && !wb_ready_o) begin
                stall_q <= sat_inc(stall_q);
            end
            if (drop_stale) begin
                drop_q <= sat_inc(drop_q);
            end
        end
    end

    assign stat_stall_o = stall_q;
    assign stat_drop_o  = drop_q;
`endif

`ifndef SYNTHESIS
    a_fire_full : assert property (@(posedge clk) disable iff (rst)
        !(req_fire_i && full && !pop))
        else $error("request fired with outstanding limit reached");
    a_ok_empty : assert property (@(posedge clk) disable iff (rst)
        !(data_data_ok_i && (count == '0)))
        else $error("data_ok with no request in flight");
    a_cancel_le : assert property (@(posedge clk) disable iff (rst)
        cancel_q <= count)
        else $error("cancel count exceeds outstanding");
    a_hold_ovr : assert property (@(posedge clk) disable iff (rst)
        !(live && hold_v_q && !wb_consume_i))
        else $error("live load overwrote unconsumed held data");
`endif

endmodule

// File: tb/tb_mem_resp_ctrl.sv
module tb_mem_resp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_fire, req_wr, data_ok, wb_need, wb_consume, flush;
    logic [31:0] rdata;
    logic        req_allow, wb_ready, busy;
    logic [31:0] wb_rdata;
    logic [2:0]  outst;
`ifdef MEM_RESP_STAT_EN
    logic [31:0] stat_stall, stat_drop;
`endif

    always #5 clk = ~clk;

    mem_resp_ctrl #(
        .MAX_OUTST (2),
        .DATA_W    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_fire_i     (req_fire),
        .req_wr_i       (req_wr),
        .req_allow_o    (req_allow),
        .data_data_ok_i (data_ok),
        .data_rdata_i   (rdata),
        .wb_need_i      (wb_need),
        .wb_consume_i   (wb_consume),
        .wb_ready_o     (wb_ready),
        .wb_rdata_o     (wb_rdata),
        .flush_i        (flush),
        .outst_cnt_o    (outst),
        .busy_o         (busy)
`ifdef MEM_RESP_STAT_EN
        ,
        .stat_stall_o   (stat_stall),
        .stat_drop_o    (stat_drop)
`endif
    );

    typedef struct {
        logic        fire, wr, ok;
        logic [31:0] rd;
        logic        need, cons, fl;
        logic        e_allow, e_ready;
        logic [31:0] e_rd;
        logic [2:0]  e_outst;
        logic        e_busy;
    } vec_t;

    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: request kinds in flight, stale count, expected WB data queue.
    logic        kind_q[$];
    int          m_cancel = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic f, w, o, input logic [31:0] rd, input logic n, c, fl,
                       input logic ea, er, input logic [31:0] erd, input logic [2:0] eo,
                       input logic eb);
        vec_t v;
        v = '{f, w, o, rd, n, c, fl, ea, er, erd, eo, eb};
        tbl.push_back(v);
    endtask

    task automatic model_step();
        logic k;
        if (data_ok && kind_q.size() > 0) begin
            k = kind_q.pop_front();
            if (m_cancel > 0) m_cancel--;
            else if (!k && !flush) exp_q.push_back(rdata);
        end
        if (flush) m_cancel = kind_q.size() + (req_fire ? 1 : 0);
        if (req_fire) kind_q.push_back(req_wr);
    endtask

    task automatic sb_check(input string tag);
        if (wb_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_unexpected_ready"}, wb_ready, 1'b0);
            end else begin
                check({tag, "_sb_data"}, wb_rdata, exp_q[0]);
                if (wb_consume) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic cyc(input vec_t v, input string tag);
        req_fire = v.fire; req_wr = v.wr; data_ok = v.ok; rdata = v.rd;
        wb_need = v.need; wb_consume = v.cons; flush = v.fl;
        #1;
        model_step();
        check({tag, "_allow"}, req_allow, v.e_allow);
        check({tag, "_ready"}, wb_ready, v.e_ready);
        check({tag, "_rdata"}, wb_rdata, v.e_rd);
        check({tag, "_outst"}, outst, v.e_outst);
        check({tag, "_busy"}, busy, v.e_busy);
        sb_check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic hs(input logic f, w, o, input logic [31:0] rd, input logic n, c, fl,
                      input logic ea, er, input logic [31:0] erd, input logic [2:0] eo,
                      input logic eb, input string tag);
        vec_t v;
        v = '{f, w, o, rd, n, c, fl, ea, er, erd, eo, eb};
        cyc(v, tag);
    endtask

    initial begin
        rst = 1'b1;
        req_fire = 0; req_wr = 0; data_ok = 0; rdata = '0;
        wb_need = 0; wb_consume = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_allow", req_allow, 1'b1);
        check("rst_ready", wb_ready, 1'b0);
        check("rst_rdata", wb_rdata, 32'h0);
        check("rst_outst", outst, 3'd0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        //   fire wr ok rdata          need cons fl | allow ready rdata         outst busy
        // Load bypass 3 cycles after issue
        add(1, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd1, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd1, 1);
        add(0, 0, 1, 32'hDEADBEEF,  1, 1, 0,   1, 1, 32'hDEADBEEF,  3'd1, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        // Load data before WB needs it: held, then delivered and cleared on consume
        add(1, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        add(0, 0, 1, 32'h1234,      0, 0, 0,   1, 0, 32'h0,         3'd1, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 1);
        add(0, 0, 0, 32'h0,         1, 0, 0,   1, 1, 32'h1234,      3'd0, 1);
        add(0, 0, 0, 32'h0,         1, 1, 0,   1, 1, 32'h1234,      3'd0, 1);
        add(0, 0, 0, 32'h0,         1, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        // Store then load: store ack dropped, load delivered
        add(1, 1, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        add(1, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd1, 1);
        add(0, 0, 1, 32'hFFFF0000,  1, 0, 0,   0, 0, 32'h0,         3'd2, 1);
        add(0, 0, 1, 32'hA5A5A5A5,  1, 1, 0,   1, 1, 32'hA5A5A5A5,  3'd1, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        // Limit reached; data_ok + fire in the same cycle keeps outst at the limit
        add(1, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);
        add(1, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd1, 1);
        add(1, 0, 1, 32'h11111111,  1, 1, 0,   0, 1, 32'h11111111,  3'd2, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   0, 0, 32'h0,         3'd2, 1);
        add(0, 0, 1, 32'h22222222,  1, 1, 0,   0, 1, 32'h22222222,  3'd2, 1);
        add(0, 0, 1, 32'h33333333,  1, 1, 0,   1, 1, 32'h33333333,  3'd1, 1);
        add(0, 0, 0, 32'h0,         0, 0, 0,   1, 0, 32'h0,         3'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i], $sformatf("v%0d", i));
        end

        // Two loads in flight, flush: both responses dropped, then idle
        hs(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0, 3'd0, 0, "fl2_a");
        hs(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0, 3'd1, 1, "fl2_b");
        hs(0, 0, 0, 32'h0,        1, 0, 1,  0, 0, 32'h0, 3'd2, 1, "fl2_flush");
        hs(0, 0, 1, 32'hBAD00001, 1, 0, 0,  0, 0, 32'h0, 3'd2, 1, "fl2_drop1");
        hs(0, 0, 1, 32'hBAD00002, 1, 0, 0,  1, 0, 32'h0, 3'd1, 1, "fl2_drop2");
        hs(0, 0, 0, 32'h0,        1, 0, 0,  1, 0, 32'h0, 3'd0, 0, "fl2_idle");

        // Flush coincident with a fire and a live response at outst=1
        hs(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0,        3'd0, 0, "fl1_a");
        hs(1, 0, 1, 32'hCAFEF00D, 1, 0, 1,  1, 0, 32'h0,        3'd1, 1, "fl1_flush");
        hs(0, 0, 0, 32'h0,        1, 0, 0,  1, 0, 32'h0,        3'd1, 1, "fl1_nohold");
        hs(0, 0, 1, 32'h55555555, 1, 0, 0,  1, 0, 32'h0,        3'd1, 1, "fl1_drop");
        hs(0, 0, 0, 32'h0,        1, 0, 0,  1, 0, 32'h0,        3'd0, 0, "fl1_idle");
        hs(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0,        3'd0, 0, "fl1_new");
        hs(0, 0, 1, 32'h77777777, 1, 1, 0,  1, 1, 32'h77777777, 3'd1, 1, "fl1_live");
        hs(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0,        3'd0, 0, "fl1_end");

        // Flush with nothing in flight stays idle
        hs(0, 0, 0, 32'h0,        0, 0, 1,  1, 0, 32'h0,        3'd0, 0, "fl0_flush");
        hs(0, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0,        3'd0, 0, "fl0_idle");

        // Reset while holding load data
        hs(1, 0, 0, 32'h0,        0, 0, 0,  1, 0, 32'h0,        3'd0, 0, "mr_fire");
        hs(0, 0, 1, 32'h0000BEEF, 0, 0, 0,  1, 0, 32'h0,        3'd1, 1, "mr_hold");
        rst = 1'b1;
        req_fire = 0; data_ok = 0; wb_need = 0; wb_consume = 0; flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        kind_q.delete();
        exp_q.delete();
        m_cancel = 0;
        hs(0, 0, 0, 32'h0,        1, 0, 0,  1, 0, 32'h0,        3'd0, 0, "mr_after");

        check("sb_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
